traffic_fsm: RTL and testbench

- Next-state logic and state register for the two-road (A/B) traffic light controller.
- Sits directly upstream of the output-decode stage and drives its 2-bit state input q.
- Adds a second-tick prescaler, a minimum-green hold, and a fixed yellow duration, driven by traffic sensors Ta and Tb.
- State encoding: 00 = A green, 01 = A yellow, 10 = B green, 11 = B yellow.

---
 rtl/traffic_fsm.sv | 55 +++++
 tb/tb_traffic_fsm.sv | 116 +++++++++++
 2 files changed

// File: rtl/traffic_fsm.sv
// traffic_fsm: two-road light controller state register with tick prescaler, min-green hold and fixed yellow
module traffic_fsm #(
  parameter int TICK_DIV        = 4,
  parameter int MIN_GREEN_TICKS = 2,
  parameter int YELLOW_TICKS    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] q,
  output logic       tick,
  output logic       chg
);
  localparam int CMAX = (MIN_GREEN_TICKS > YELLOW_TICKS) ? MIN_GREEN_TICKS : YELLOW_TICKS;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CSAT  = CW'(CMAX);
  localparam logic [CW:0]   MG    = (CW + 1)'(MIN_GREEN_TICKS);
  localparam logic [CW:0]   YT    = (CW + 1)'(YELLOW_TICKS);
  typedef enum logic [1:0] {A_GRN = 2'b00, A_YEL = 2'b01, B_GRN = 2'b10, B_YEL = 2'b11} state_t;
  state_t          st, nxt;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   cnt;
  logic [CW:0]     n;
  logic            trans;
  assign tick  = (presc == PLAST);
  assign n     = {1'b0, cnt} + 1'b1;
  assign trans = (nxt != st);
  assign q     = st;
  // transitions are only ever taken on tick cycles, so sensors are effectively sampled per tick
  always_comb begin
    nxt = A_GRN;
    case (st)
      A_GRN:   nxt = (tick && n >= MG && !Ta) ? A_YEL : A_GRN;
      A_YEL:   nxt = (tick && n == YT) ? B_GRN : A_YEL;
      B_GRN:   nxt = (tick && n >= MG && !Tb) ? B_YEL : B_GRN;
      default: nxt = (tick && n == YT) ? A_GRN : B_YEL;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= A_GRN;
      presc <= '0;
      cnt   <= '0;
      chg   <= 1'b0;
    end else begin
      st    <= nxt;
      chg   <= trans;
      presc <= (trans || tick) ? '0 : presc + 1'b1;
      cnt   <= trans ? '0 : (tick && cnt != CSAT) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_traffic_fsm.sv
// tb_traffic_fsm: directed checks of traffic_fsm timing, sensors, async reset and the all-ones parameter set
module tb_traffic_fsm;
  logic       clk = 1'b0;
  logic       reset, reset2;
  logic       Ta, Tb;
  logic [1:0] q, q2;
  logic       tick, tick2, chg, chg2;
  int         cyc, errors, checks;

  traffic_fsm dut (.clk(clk), .reset(reset), .Ta(Ta), .Tb(Tb), .q(q), .tick(tick), .chg(chg));
  traffic_fsm #(.TICK_DIV(1), .MIN_GREEN_TICKS(1), .YELLOW_TICKS(1)) dut2 (
    .clk(clk), .reset(reset2), .Ta(1'b0), .Tb(1'b0), .q(q2), .tick(tick2), .chg(chg2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    Ta = 1'b0;
    Tb = 1'b0;
    release_rst();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    reset2 = 1'b1;
    Ta = 1'b0;
    Tb = 1'b0;
    cyc = 0;
    repeat (2) @(posedge clk);
    // defaults, no traffic
    do_reset();
    chk("rst_q", q, 0);
    chk("rst_chg", chg, 0);
    chk("rst_tick", tick, 0);
    go(3);  chk("tick_c4", tick, 1);
    go(4);  chk("tick_c5", tick, 0); chk("q_hold_min", q, 0);
    go(7);  chk("tick_c8", tick, 1); chk("q_pre8", q, 0);
    go(8);  chk("q_e8", q, 1); chk("chg_c9", chg, 1);
    go(9);  chk("chg_c10", chg, 0);
    go(27); chk("q_e27", q, 1);
    go(28); chk("q_e28", q, 2); chk("chg_e28", chg, 1);
    go(35); chk("q_e35", q, 2);
    go(36); chk("q_e36", q, 3);
    go(55); chk("q_e55", q, 3);
    go(56); chk("q_e56", q, 0); chk("chg_e56", chg, 1);
    // Ta held then dropped
    do_reset();
    Ta = 1'b1;
    go(40); chk("ta_hold_e40", q, 0); chk("ta_chg_e40", chg, 0);
    Ta = 1'b0;
    go(43); chk("ta_q_e43", q, 0);
    go(44); chk("ta_q_e44", q, 1); chk("ta_chg_e44", chg, 1);
    // Ta pulse on a non-tick cycle
    do_reset();
    go(5);  Ta = 1'b1;
    go(6);  Ta = 1'b0;
    go(7);  chk("pulse_q_e7", q, 0);
    go(8);  chk("pulse_q_e8", q, 1);
    // asynchronous reset mid-yellow
    do_reset();
    go(14); chk("mid_yel_q", q, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_q", q, 0);
    chk("async_chg", chg, 0);
    release_rst();
    go(7);  chk("rerun_q_e7", q, 0);
    go(8);  chk("rerun_q_e8", q, 1);
    // Tb sustained: parks in B green
    do_reset();
    Tb = 1'b1;
    go(28); chk("tb_q_e28", q, 2);
    go(60); chk("tb_q_e60", q, 2); chk("tb_chg_e60", chg, 0); chk("tb_cnt_sat", dut.cnt, 5);
    go(63); chk("tb_tick_c64", tick, 1);
    go(64); chk("tb_tick_c65", tick, 0); chk("tb_q_e64", q, 2); chk("tb_chg_e64", chg, 0);
    // all parameters at 1
    @(negedge clk);
    reset2 = 1'b0;
    cyc = 0;
    #1;
    chk("p1_rst_q", q2, 0);
    chk("p1_tick", tick2, 1);
    go(1); chk("p1_q_e1", q2, 1); chk("p1_chg_e1", chg2, 1);
    go(2); chk("p1_q_e2", q2, 2); chk("p1_chg_e2", chg2, 1);
    go(3); chk("p1_q_e3", q2, 3);
    go(4); chk("p1_q_e4", q2, 0); chk("p1_chg_e4", chg2, 1); chk("p1_tick_e4", tick2, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
